// File: rtl/spectrum_peak_detector.sv
// Streaming per-frame spectrum statistics: peak power, its bin index, saturating
// energy sum and bin count, delivered through a one-deep result slot.
module spectrum_peak_detector #(
   parameter int I_BW  = 32,
   parameter int BIN_W = 10,
   parameter int SUM_W = 42
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic [I_BW-1:0]    data_i,
   input  logic               valid_i,
   input  logic               last_i,
   output logic [I_BW-1:0]    peak_o,
   output logic [BIN_W-1:0]   peak_bin_o,
   output logic [SUM_W-1:0]   energy_o,
   output logic [BIN_W:0]     bins_o,
   output logic               trunc_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               overrun_o
);

   localparam int SW1 = SUM_W + 1;
   localparam int BW1 = BIN_W + 1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   slot_e              slot_q, slot_d;
   logic [BIN_W-1:0]   cnt_q;
   logic [I_BW-1:0]    peak_q;
   logic [BIN_W-1:0]   idx_q;
   logic [SUM_W-1:0]   energy_q;

   logic               first_beat, at_limit, frame_end, take;
   logic [I_BW-1:0]    beat_peak;
   logic [BIN_W-1:0]   beat_idx;
   logic [SW1-1:0]     sum_ext;
   logic [SUM_W-1:0]   beat_energy;
   logic [BIN_W:0]     beat_bins;
   logic               load, drop;

   // Accumulators sit at zero between frames, so a zero count marks the first beat.
   assign first_beat  = (cnt_q == '0);
   assign at_limit    = (cnt_q == {BIN_W{1'b1}});
   assign frame_end   = valid_i & (last_i | at_limit);
   assign take        = first_beat | (data_i > peak_q);
   assign beat_peak   = take ? data_i : peak_q;
   assign beat_idx    = take ? cnt_q : idx_q;
   assign sum_ext     = {1'b0, energy_q} + SW1'(data_i);
   assign beat_energy = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
   assign beat_bins   = {1'b0, cnt_q} + BW1'(1);

   always_comb begin
      slot_d = slot_q;
      load   = 1'b0;
      drop   = 1'b0;
      case (slot_q)
         SLOT_EMPTY: begin
            if (frame_end) begin
               slot_d = SLOT_FULL;
               load   = 1'b1;
            end
         end
         SLOT_FULL: begin
            if (frame_end) begin
               load = ready_i;
               drop = ~ready_i;
            end else if (ready_i) begin
               slot_d = SLOT_EMPTY;
            end
         end
         default: slot_d = SLOT_EMPTY;
      endcase
   end

   // NOTE: rst_i and a low en_i share one synchronous clear path; every register,
   // including the result slot, returns to zero so outputs read 0 while EMPTY.
   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         cnt_q    <= '0;
         peak_q   <= '0;
         idx_q    <= '0;
         energy_q <= '0;
      end else if (valid_i) begin
         if (frame_end) begin
            cnt_q    <= '0;
            peak_q   <= '0;
            idx_q    <= '0;
            energy_q <= '0;
         end else begin
            cnt_q    <= cnt_q + BIN_W'(1);
            peak_q   <= beat_peak;
            idx_q    <= beat_idx;
            energy_q <= beat_energy;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         slot_q     <= SLOT_EMPTY;
         peak_o     <= '0;
         peak_bin_o <= '0;
         energy_o   <= '0;
         bins_o     <= '0;
         trunc_o    <= 1'b0;
         overrun_o  <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         overrun_o <= drop;
         if (load) begin
            peak_o     <= beat_peak;
            peak_bin_o <= beat_idx;
            energy_o   <= beat_energy;
            bins_o     <= beat_bins;
            trunc_o    <= at_limit & ~last_i;
         end else if (slot_d == SLOT_EMPTY) begin
            peak_o     <= '0;
            peak_bin_o <= '0;
            energy_o   <= '0;
            bins_o     <= '0;
            trunc_o    <= 1'b0;
         end
      end
   end

   assign valid_o = (slot_q == SLOT_FULL);

endmodule

// File: doc/spectrum_peak_detector.md
SPECTRUM_PEAK_DETECTOR -- requirements
Module: spectrum_peak_detector

Interface
REQ-001 Parameter I_BW, default 32, width of unsigned power-bin input.
REQ-002 Parameter BIN_W, default 10, bin-index width; max frame length 2^BIN_W bins.
REQ-003 Parameter SUM_W, default 42, width of frame-energy accumulator.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 en_i  input  1  block enable; low = synchronous clear.
REQ-007 data_i  input  I_BW  unsigned bin power.
REQ-008 valid_i  input  1  data_i qualifier; no backpressure, every valid beat consumed.
REQ-009 last_i  input  1  final bin of frame, qualified by valid_i.
REQ-010 peak_o  output  I_BW  maximum bin power of reported frame.
REQ-011 peak_bin_o  output  BIN_W  0-based index of peak bin.
REQ-012 energy_o  output  SUM_W  saturating sum of all bins in frame.
REQ-013 bins_o  output  BIN_W+1  bin count of frame.
REQ-014 trunc_o  output  1  frame force-terminated at max length.
REQ-015 valid_o  output  1  result valid; held until accepted.
REQ-016 ready_i  input  1  downstream accept; transfer when valid_o & ready_i.
REQ-017 overrun_o  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-018 Accumulator state: bin counter, running peak/index, running energy; frame in progress after first valid beat, idle after frame end.
REQ-019 Beat index = bin counter value before increment; counter increments per valid beat.
REQ-020 First beat of frame loads peak and index unconditionally; later beats replace only if data_i strictly greater (ties keep earliest index).
REQ-021 Energy adds zero-extended data_i per beat, saturating at 2^SUM_W-1; no wrap.
REQ-022 Frame end = valid_i & (last_i | beat index == 2^BIN_W-1); trunc set iff end caused by index limit with last_i=0.
REQ-023 On frame end, final values including the ending beat go to result slot, accumulators clear same edge; next cycle's valid beat starts new frame (back-to-back frames, zero gap, supported).
REQ-024 Latency: valid_o asserts cycle after ending beat.
REQ-025 Result slot EMPTY->FULL on frame end; FULL->EMPTY on valid_o & ready_i with no simultaneous frame end.
REQ-026 FULL, ready_i high, frame end same cycle: new result loads, valid_o stays high, no overrun.
REQ-027 FULL, ready_i low, frame end: new result dropped, slot unchanged, overrun_o=1 for that one cycle.
REQ-028 Outputs stable while valid_o high and not accepted; peak_o/peak_bin_o/energy_o/bins_o/trunc_o zero when slot EMPTY.
REQ-029 Single-beat frame (valid_i & last_i on first beat): peak=data, index 0, energy=data, bins=1.
REQ-030 en_i low: clears accumulators and result slot as reset, ignores inputs, overrun_o=0; resumes in idle when en_i returns high.

Reset
REQ-031 rst_i high at clock edge: all outputs 0, slot EMPTY, accumulators cleared, partial frame discarded; rst_i priority over en_i.
REQ-032 Mid-frame reset: beats after release start new frame at index 0; no result for discarded partial frame.

Verification
REQ-033 4-bin frame 5,9,9,2, last on 2, ready_i=1 -> one cycle later valid_o=1, peak 9, bin 1, energy 25, bins 4, trunc 0.
REQ-034 Two back-to-back frames {3,7} and {8}, ready_i=0 until second end -> first result held, overrun_o pulses once at second end, outputs 7/1/10/2.
REQ-035 Same as 034 with ready_i=1 at second frame end -> second result 8/0/8/1 loaded, no overrun.
REQ-036 BIN_W=3, 8 beats of 1 without last, 9th beat 4 with last -> result 1/0/8/8 trunc=1; then 4/0/4/1 trunc=0.
REQ-037 SUM_W=33, two beats 0xFFFFFFFF -> energy 0x1FFFFFFFE; third beat 0xFFFFFFFF -> saturates 0x1FFFFFFFF.
REQ-038 rst_i or en_i low after 2 beats of a frame, then frame 6 with last -> valid_o 0 during clear, then result 6/0/6/1.
